// File: rtl/coherent_mem_arbiter.sv
// Shared-RAM bus arbiter with snooping coherence for CPUS private I/D L1 pairs.
// Serves data writebacks, coherent block reads (from RAM or via cache-to-cache
// transfer with a simultaneous RAM update) and single-word instruction fetches.
module coherent_mem_arbiter #(
    parameter int CPUS   = 2,
    parameter int WORDS  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS*ADDR_W-1:0] iaddr,
    output logic [CPUS-1:0]        iwait,
    output logic [CPUS*DATA_W-1:0] iload,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS*ADDR_W-1:0] daddr,
    input  logic [CPUS*DATA_W-1:0] dstore,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS*DATA_W-1:0] dload,
    input  logic [CPUS-1:0]        ccwrite,
    input  logic [CPUS-1:0]        cctrans,
    output logic [CPUS-1:0]        ccwait,
    output logic [CPUS-1:0]        ccinv,
    output logic [CPUS*ADDR_W-1:0] ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [ADDR_W-1:0]      ramaddr,
    output logic [DATA_W-1:0]      ramstore,
    input  logic [DATA_W-1:0]      ramload,
    input  logic [1:0]             ramstate
);

    localparam int SEL_W = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(WORDS - 1);
    localparam logic [1:0]       RAM_ACCESS = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_WB, S_SNOOP, S_RDMEM, S_C2C, S_IFETCH
    } state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d, owner_q, owner_d;
    logic [SEL_W-1:0] dptr_q, dptr_d, iptr_q, iptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             ram_access;
    logic [CPUS-1:0]  others;
    logic [SEL_W:0]   pick_wb, pick_rd, pick_if;
    logic [SEL_W-1:0] snoop_owner;

    // Round-robin pick: first requester at or after ptr; MSB flags a hit.
    function automatic logic [SEL_W:0] rr_pick(input logic [CPUS-1:0] req,
                                               input logic [SEL_W-1:0] ptr);
        logic [SEL_W:0] r;
        r = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % CPUS;
            if (req[idx]) r = {1'b1, SEL_W'(idx)};
        end
        return r;
    endfunction

    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] idx);
        return SEL_W'((int'(idx) + 1) % CPUS);
    endfunction

    assign ram_access = (ramstate == RAM_ACCESS);
    assign others     = ~(CPUS'(1) << sel_q);
    assign pick_wb    = rr_pick(dWEN, dptr_q);
    assign pick_rd    = rr_pick(dREN, dptr_q);
    assign pick_if    = rr_pick(iREN, iptr_q);

    // Lowest-indexed remote cache reporting a Modified copy.
    always_comb begin
        snoop_owner = '0;
        for (int j = CPUS - 1; j >= 0; j--) begin
            if (ccwrite[j] && others[j]) snoop_owner = SEL_W'(j);
        end
    end

    // Next-state logic: arbitration in IDLE, beat counting, snoop resolution.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        sel_d   = sel_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        dptr_d  = dptr_q;
        iptr_d  = iptr_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_wb[SEL_W]) begin
                    sel_d   = pick_wb[SEL_W-1:0];
                    dptr_d  = next_ptr(pick_wb[SEL_W-1:0]);
                    cnt_d   = '0;
                    state_d = S_WB;
                end else if (pick_rd[SEL_W]) begin
                    sel_d   = pick_rd[SEL_W-1:0];
                    dptr_d  = next_ptr(pick_rd[SEL_W-1:0]);
                    cnt_d   = '0;
                    state_d = S_SNOOP;
                end else if (pick_if[SEL_W]) begin
                    sel_d   = pick_if[SEL_W-1:0];
                    iptr_d  = next_ptr(pick_if[SEL_W-1:0]);
                    cnt_d   = '0;
                    state_d = S_IFETCH;
                end
            end
            S_WB, S_RDMEM, S_C2C: begin
                if (ram_access) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) state_d = S_IDLE;
                end
            end
            S_SNOOP: begin
                if (|(cctrans & others)) begin
                    state_d = S_SNOOP;
                end else if (|(ccwrite & others)) begin
                    owner_d = snoop_owner;
                    state_d = S_C2C;
                end else begin
                    state_d = S_RDMEM;
                end
            end
            S_IFETCH: begin
                if (ram_access) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, selection, pointer and beat-counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            dptr_q  <= '0;
            iptr_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q <= state_d;
            sel_q   <= sel_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            dptr_q  <= dptr_d;
            iptr_q  <= iptr_d;
        end
    end

    // Bus and coherence outputs decoded from the registered state.
    always_comb begin
        iwait       = '1;
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iload       = '0;
        dload       = '0;
        unique case (state_q)
            S_WB: begin
                ramWEN       = 1'b1;
                ramaddr      = daddr[int'(sel_q)*ADDR_W +: ADDR_W];
                ramstore     = dstore[int'(sel_q)*DATA_W +: DATA_W];
                dwait[sel_q] = ~ram_access;
            end
            S_SNOOP: begin
                for (int j = 0; j < CPUS; j++) begin
                    ccsnoopaddr[j*ADDR_W +: ADDR_W] = daddr[int'(sel_q)*ADDR_W +: ADDR_W];
                    if (others[j]) begin
                        ccwait[j] = 1'b1;
                        ccinv[j]  = ccwrite[sel_q];
                    end
                end
            end
            S_C2C: begin
                for (int j = 0; j < CPUS; j++) begin
                    ccsnoopaddr[j*ADDR_W +: ADDR_W] = daddr[int'(sel_q)*ADDR_W +: ADDR_W];
                end
                // Owner stays frozen except on the beat it sees its own dwait drop.
                ccwait[owner_q] = ~ram_access;
                ramWEN          = 1'b1;
                ramaddr         = daddr[int'(owner_q)*ADDR_W +: ADDR_W];
                ramstore        = dstore[int'(owner_q)*DATA_W +: DATA_W];
                dload[int'(sel_q)*DATA_W +: DATA_W] = dstore[int'(owner_q)*DATA_W +: DATA_W];
                dwait[sel_q]    = ~ram_access;
                dwait[owner_q]  = ~ram_access;
            end
            S_RDMEM: begin
                ramREN       = 1'b1;
                ramaddr      = daddr[int'(sel_q)*ADDR_W +: ADDR_W];
                dload[int'(sel_q)*DATA_W +: DATA_W] = ramload;
                dwait[sel_q] = ~ram_access;
            end
            S_IFETCH: begin
                ramREN       = 1'b1;
                ramaddr      = iaddr[int'(sel_q)*ADDR_W +: ADDR_W];
                iload[int'(sel_q)*DATA_W +: DATA_W] = ramload;
                iwait[sel_q] = ~ram_access;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherent_mem_arbiter.sv
// Directed bench: a 2-CPU/2-word instance for writeback, snoop, RAM read and
// cache-to-cache paths, plus a 4-CPU instance for fetch fairness and class priority.
module tb_coherent_mem_arbiter;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;
    localparam logic [31:0] RAM_KEY = 32'hA5A5_0000;

    logic CLK, nRST;
    int   n_pass, n_total;

    // 2-CPU instance
    logic [1:0]  iREN, iwait, dREN, dWEN, dwait, ccwrite, cctrans, ccwait, ccinv;
    logic [63:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    // 4-CPU instance
    logic [3:0]   iREN4, iwait4, dREN4, dWEN4, dwait4, ccwrite4, cctrans4, ccwait4, ccinv4;
    logic [127:0] iaddr4, iload4, daddr4, dstore4, dload4, ccsnoopaddr4;
    logic         ramREN4, ramWEN4;
    logic [31:0]  ramaddr4, ramstore4, ramload4;
    logic [1:0]   ramstate4;

    // RAM model for the 4-CPU instance: data is a fixed function of the address.
    assign ramload4 = ramaddr4 ^ RAM_KEY;

    coherent_mem_arbiter #(.CPUS(2), .WORDS(2), .ADDR_W(32), .DATA_W(32)) u_dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ccwrite(ccwrite), .cctrans(cctrans), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    coherent_mem_arbiter #(.CPUS(4), .WORDS(2), .ADDR_W(32), .DATA_W(32)) u_dut4 (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN4), .iaddr(iaddr4), .iwait(iwait4), .iload(iload4),
        .dREN(dREN4), .dWEN(dWEN4), .daddr(daddr4), .dstore(dstore4),
        .dwait(dwait4), .dload(dload4),
        .ccwrite(ccwrite4), .cctrans(cctrans4), .ccwait(ccwait4), .ccinv(ccinv4),
        .ccsnoopaddr(ccsnoopaddr4),
        .ramREN(ramREN4), .ramWEN(ramWEN4), .ramaddr(ramaddr4), .ramstore(ramstore4),
        .ramload(ramload4), .ramstate(ramstate4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
        ccwrite = '0; cctrans = '0; ramload = '0; ramstate = FREE;
        iREN4 = '0; iaddr4 = '0; dREN4 = '0; dWEN4 = '0; daddr4 = '0; dstore4 = '0;
        ccwrite4 = '0; cctrans4 = '0; ramstate4 = FREE;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 1'b0;
        #3;
        n_total++; if (iwait !== 2'b11) $display("FAIL rst_iwait got %b exp 11", iwait); else n_pass++;
        n_total++; if (dwait !== 2'b11) $display("FAIL rst_dwait got %b exp 11", dwait); else n_pass++;
        n_total++; if ({ccwait, ccinv} !== 4'b0) $display("FAIL rst_cc got %b exp 0000", {ccwait, ccinv}); else n_pass++;
        n_total++; if ({ramREN, ramWEN} !== 2'b00) $display("FAIL rst_ram_strobes got %b exp 00", {ramREN, ramWEN}); else n_pass++;
        n_total++; if ({ramaddr, ramstore} !== 64'h0) $display("FAIL rst_ram_bus got %h exp 0", {ramaddr, ramstore}); else n_pass++;
        n_total++; if ({dload, iload} !== 128'h0) $display("FAIL rst_loads got %h exp 0", {dload, iload}); else n_pass++;
        n_total++; if (iwait4 !== 4'hF) $display("FAIL rst_iwait4 got %b exp 1111", iwait4); else n_pass++;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_wb();
        int lows;
        lows = 0;
        @(negedge CLK);
        dWEN = 2'b10; daddr[63:32] = 32'h100; dstore[63:32] = 32'hA; ramstate = FREE;
        #1;
        n_total++; if (ramWEN !== 1'b0) $display("FAIL wb_idle ramWEN got %b exp 0", ramWEN); else n_pass++;
        @(negedge CLK);
        ramstate = BUSY;
        #1;
        n_total++; if ({ramWEN, ramaddr, ramstore} !== {1'b1, 32'h100, 32'hA})
            $display("FAIL wb_beat0_bus got %b/%h/%h exp 1/100/a", ramWEN, ramaddr, ramstore); else n_pass++;
        n_total++; if (dwait !== 2'b11) $display("FAIL wb_busy_dwait got %b exp 11", dwait); else n_pass++;
        lows += int'(!dwait[1]);
        @(negedge CLK);
        ramstate = ACCESS;
        #1;
        n_total++; if (dwait !== 2'b01) $display("FAIL wb_beat0_dwait got %b exp 01", dwait); else n_pass++;
        lows += int'(!dwait[1]);
        @(negedge CLK);
        ramstate = BUSY; daddr[63:32] = 32'h104; dstore[63:32] = 32'hB;
        #1;
        n_total++; if ({ramWEN, ramaddr, ramstore, dwait} !== {1'b1, 32'h104, 32'hB, 2'b11})
            $display("FAIL wb_beat1_bus got %b/%h/%h/%b exp 1/104/b/11", ramWEN, ramaddr, ramstore, dwait); else n_pass++;
        lows += int'(!dwait[1]);
        @(negedge CLK);
        ramstate = ACCESS;
        #1;
        n_total++; if (dwait !== 2'b01) $display("FAIL wb_beat1_dwait got %b exp 01", dwait); else n_pass++;
        lows += int'(!dwait[1]);
        @(negedge CLK);
        dWEN = 2'b00; ramstate = FREE;
        #1;
        n_total++; if ({ramWEN, dwait} !== 3'b011) $display("FAIL wb_done got %b exp 011", {ramWEN, dwait}); else n_pass++;
        n_total++; if (lows !== 2) $display("FAIL wb_dwait_lows got %0d exp 2", lows); else n_pass++;
    endtask

    task automatic test_reset_mid_wb();
        @(negedge CLK);
        dWEN = 2'b01; daddr[31:0] = 32'h40; dstore[31:0] = 32'h55; ramstate = FREE;
        @(negedge CLK);
        ramstate = ACCESS;
        #1;
        n_total++; if (dwait !== 2'b10) $display("FAIL mid_beat0_dwait got %b exp 10", dwait); else n_pass++;
        @(negedge CLK);
        ramstate = BUSY;
        #1;
        n_total++; if (ramWEN !== 1'b1) $display("FAIL mid_beat1_ramWEN got %b exp 1", ramWEN); else n_pass++;
        #2 nRST = 1'b0;
        #1;
        n_total++; if ({ramWEN, dwait, ramaddr} !== {1'b0, 2'b11, 32'h0})
            $display("FAIL mid_async_rst got %b/%b/%h exp 0/11/0", ramWEN, dwait, ramaddr); else n_pass++;
        @(negedge CLK);
        nRST = 1'b1; ramstate = FREE;
        #1;
        n_total++; if ({ramWEN, dwait} !== 3'b011) $display("FAIL mid_idle got %b exp 011", {ramWEN, dwait}); else n_pass++;
        @(negedge CLK);
        ramstate = ACCESS;
        #1;
        n_total++; if ({ramWEN, ramaddr, dwait} !== {1'b1, 32'h40, 2'b10})
            $display("FAIL mid_redo_beat0 got %b/%h/%b exp 1/40/10", ramWEN, ramaddr, dwait); else n_pass++;
        @(negedge CLK);
        #1;
        n_total++; if ({ramWEN, dwait} !== 3'b110) $display("FAIL mid_redo_beat1 got %b exp 110", {ramWEN, dwait}); else n_pass++;
        @(negedge CLK);
        dWEN = 2'b00; ramstate = FREE;
        #1;
        n_total++; if (ramWEN !== 1'b0) $display("FAIL mid_redo_done ramWEN got %b exp 0", ramWEN); else n_pass++;
    endtask

    task automatic test_snoop_rdmem();
        @(negedge CLK);
        dREN = 2'b01; ccwrite = 2'b01; daddr[31:0] = 32'h200; cctrans = 2'b10; ramstate = FREE;
        #1;
        n_total++; if (ccwait !== 2'b00) $display("FAIL snp_idle ccwait got %b exp 00", ccwait); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            cctrans = (i < 3) ? 2'b10 : 2'b00;
            #1;
            n_total++; if ({ccwait, ccinv, ramREN, ramWEN} !== 6'b10_10_00)
                $display("FAIL snp_cycle%0d got %b exp 101000", i, {ccwait, ccinv, ramREN, ramWEN}); else n_pass++;
            n_total++; if (ccsnoopaddr[63:32] !== 32'h200)
                $display("FAIL snp_addr%0d got %h exp 200", i, ccsnoopaddr[63:32]); else n_pass++;
        end
        @(negedge CLK);
        ramstate = ACCESS; ramload = 32'h11;
        #1;
        n_total++; if ({ramREN, ramaddr, dload[31:0], dwait, ccwait} !== {1'b1, 32'h200, 32'h11, 2'b10, 2'b00})
            $display("FAIL rd_beat0 got %b/%h/%h/%b/%b exp 1/200/11/10/00", ramREN, ramaddr, dload[31:0], dwait, ccwait); else n_pass++;
        @(negedge CLK);
        ramload = 32'h22; daddr[31:0] = 32'h204;
        #1;
        n_total++; if ({ramaddr, dload[31:0], dwait} !== {32'h204, 32'h22, 2'b10})
            $display("FAIL rd_beat1 got %h/%h/%b exp 204/22/10", ramaddr, dload[31:0], dwait); else n_pass++;
        @(negedge CLK);
        dREN = 2'b00; ccwrite = 2'b00; ramstate = FREE;
        #1;
        n_total++; if ({ramREN, dwait} !== 3'b011) $display("FAIL rd_done got %b exp 011", {ramREN, dwait}); else n_pass++;
    endtask

    task automatic test_c2c();
        @(negedge CLK);
        dREN = 2'b01; daddr[31:0] = 32'h300;
        ccwrite = 2'b10; daddr[63:32] = 32'h300; dstore[63:32] = 32'hDEAD; ramstate = FREE;
        @(negedge CLK);
        #1;
        n_total++; if ({ccwait, ccinv} !== 4'b10_00) $display("FAIL c2c_snoop got %b exp 1000", {ccwait, ccinv}); else n_pass++;
        @(negedge CLK);
        ramstate = BUSY;
        #1;
        n_total++; if ({ramWEN, ramREN, ramaddr, ramstore, dload[31:0]} !== {2'b10, 32'h300, 32'hDEAD, 32'hDEAD})
            $display("FAIL c2c_bus got %b%b/%h/%h/%h exp 10/300/dead/dead", ramWEN, ramREN, ramaddr, ramstore, dload[31:0]); else n_pass++;
        n_total++; if ({dwait, ccwait[1]} !== 3'b111) $display("FAIL c2c_stall got %b exp 111", {dwait, ccwait[1]}); else n_pass++;
        @(negedge CLK);
        ramstate = ACCESS;
        #1;
        n_total++; if (dwait !== 2'b00) $display("FAIL c2c_beat0_dwait got %b exp 00", dwait); else n_pass++;
        @(negedge CLK);
        daddr[63:32] = 32'h304; dstore[63:32] = 32'hBEEF;
        #1;
        n_total++; if ({ramaddr, dload[31:0], dwait} !== {32'h304, 32'hBEEF, 2'b00})
            $display("FAIL c2c_beat1 got %h/%h/%b exp 304/beef/00", ramaddr, dload[31:0], dwait); else n_pass++;
        @(negedge CLK);
        dREN = 2'b00; ccwrite = 2'b00; ramstate = FREE;
        #1;
        n_total++; if ({ramWEN, dwait, ccwait} !== 5'b0_11_00) $display("FAIL c2c_done got %b exp 01100", {ramWEN, dwait, ccwait}); else n_pass++;
    endtask

    task automatic test_ifetch_rr();
        logic [31:0] a;
        int exp_sel;
        @(negedge CLK);
        iREN4 = 4'hF; ramstate4 = ACCESS;
        for (int k = 0; k < 4; k++) iaddr4[k*32 +: 32] = 32'h1000 + 32'(k) * 32'h10;
        for (int g = 0; g < 5; g++) begin
            @(negedge CLK);
            #1;
            exp_sel = g % 4;
            a = 32'h1000 + 32'(exp_sel) * 32'h10;
            n_total++; if (iwait4 !== ~(4'b1 << exp_sel))
                $display("FAIL rr_grant%0d iwait got %b exp cpu %0d", g, iwait4, exp_sel); else n_pass++;
            n_total++; if (iload4[exp_sel*32 +: 32] !== (a ^ RAM_KEY))
                $display("FAIL rr_iload%0d got %h exp %h", g, iload4[exp_sel*32 +: 32], a ^ RAM_KEY); else n_pass++;
            @(negedge CLK);
        end
        iREN4 = 4'h0; ramstate4 = FREE;
    endtask

    task automatic test_priority();
        @(negedge CLK);
        dWEN4 = 4'b0100; daddr4[95:64] = 32'h500; dstore4[95:64] = 32'h77;
        iREN4 = 4'b0001; iaddr4[31:0] = 32'h2000; ramstate4 = ACCESS;
        @(negedge CLK);
        #1;
        n_total++; if ({ramWEN4, ramREN4, ramaddr4, dwait4, iwait4} !== {2'b10, 32'h500, 4'b1011, 4'b1111})
            $display("FAIL prio_wb_beat0 got %b%b/%h/%b/%b exp 10/500/1011/1111", ramWEN4, ramREN4, ramaddr4, dwait4, iwait4); else n_pass++;
        @(negedge CLK);
        #1;
        n_total++; if ({ramWEN4, dwait4} !== 5'b1_1011) $display("FAIL prio_wb_beat1 got %b exp 11011", {ramWEN4, dwait4}); else n_pass++;
        @(negedge CLK);
        dWEN4 = 4'b0000;
        #1;
        n_total++; if ({ramWEN4, ramREN4} !== 2'b00) $display("FAIL prio_idle got %b exp 00", {ramWEN4, ramREN4}); else n_pass++;
        @(negedge CLK);
        #1;
        n_total++; if ({ramREN4, ramaddr4, iwait4, iload4[31:0]} !== {1'b1, 32'h2000, 4'b1110, 32'h2000 ^ RAM_KEY})
            $display("FAIL prio_ifetch got %b/%h/%b/%h exp 1/2000/1110/%h", ramREN4, ramaddr4, iwait4, iload4[31:0], 32'h2000 ^ RAM_KEY); else n_pass++;
        @(negedge CLK);
        iREN4 = 4'b0000; ramstate4 = FREE;
        #1;
        n_total++; if ({ramREN4, iwait4} !== 5'b0_1111) $display("FAIL prio_done got %b exp 01111", {ramREN4, iwait4}); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_wb();
        test_reset_mid_wb();
        test_snoop_rdmem();
        test_c2c();
        test_ifetch_rr();
        test_priority();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
